// File: rtl/apb_pkg.sv
// ============================================================================
//  apb_pkg
//  FSM state encoding and wait-counter width for the APB register slave.
//  Rev 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int c_cnt_w = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_reg_slave_if.sv
// ============================================================================
//  apb_reg_slave_if
//  APB bus bundle with master and slave views.
//  Rev 1.0
// ============================================================================
`include "apb_arch.svh"
`default_nettype none

interface apb_reg_slave_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                    sel;
    logic                    enable;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] strb;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    ready;
    logic                    slverr;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output sel, enable, write, strb, addr, wdata,
        input  ready, slverr, rdata
    );

    modport slave (
        input  sel, enable, write, strb, addr, wdata,
        output ready, slverr, rdata
    );
endinterface

`default_nettype wire

// File: rtl/apb_arch.svh
// ============================================================================
//  apb_arch.svh
//  Bus width definitions shared by the APB register slave slice.
//  Rev 1.0
// ============================================================================
`ifndef APB_ARCH_SVH
`define APB_ARCH_SVH
`default_nettype none

`define DATA_WIDTH 32
`define ADDR_WIDTH 32
`define STRB_SIZE  (`DATA_WIDTH/8)

`default_nettype wire
`endif

// File: rtl/apb_reg_file.sv
// ============================================================================
//  apb_reg_file
//  Byte-strobed register array; slot 0 has no storage and reads as zero.
//  Rev 1.0
// ============================================================================
`include "apb_arch.svh"
`default_nettype none

module apb_reg_file #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]    i_idx,
    input  logic [DATA_WIDTH/8-1:0]        i_strb,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);
    localparam int c_idx_w  = $clog2(NUM_REGS);
    localparam int c_strb_w = DATA_WIDTH/8;

    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    always_comb begin
        regs_d  = regs_q;
        o_rdata = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (i_idx == c_idx_w'(i)) begin
                o_rdata = regs_q[i];
                if (i_wr_en) begin
                    for (int b = 0; b < c_strb_w; b++) begin
                        if (i_strb[b]) begin
                            regs_d[i][8*b +: 8] = i_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            if (g == 0) begin : g_zero
                assign o_regs[0 +: DATA_WIDTH] = '0;
            end else begin : g_slot
                assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_reg_slave.sv
// ============================================================================
//  apb_reg_slave
//  APB slave with programmable wait states over a strobed register window;
//  register 0 returns a live status word.
//  Rev 1.0
// ============================================================================
`include "apb_arch.svh"
`default_nettype none

module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = `DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    apb_reg_slave_if.slave                 bus,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
    localparam int                    c_idx_w     = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] c_win_bytes = ADDR_WIDTH'(4*NUM_REGS);

    apb_state_e         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_in_range;
    logic [c_idx_w-1:0]    w_idx;
    logic                  w_idx_zero;
    logic                  w_ready;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rf_rdata;

    assign w_offset   = bus.addr - BASE_ADDR;
    assign w_in_range = (bus.addr >= BASE_ADDR) && (w_offset < c_win_bytes);
    assign w_idx      = w_offset[c_idx_w+1:2];
    assign w_idx_zero = (w_idx == '0);

    // Gated by rst so a transfer caught mid-flight by reset never completes.
    assign w_ready = !rst && (state_q == ACCESS) && bus.sel && bus.enable
                     && (cnt_q == '0);
    assign w_wr_en = w_ready && bus.write && w_in_range && !w_idx_zero;

    assign bus.ready  = w_ready;
    assign bus.slverr = w_ready && (!w_in_range || (bus.write && w_idx_zero));
    assign bus.rdata  = (w_ready && !bus.write && w_in_range)
                        ? (w_idx_zero ? status_in : w_rf_rdata)
                        : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.sel && !bus.enable) begin
                    state_d = ACCESS;
                    cnt_d   = c_cnt_w'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!bus.sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.enable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - c_cnt_w'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    apb_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_wr_en),
        .i_idx   (w_idx),
        .i_strb  (bus.strb),
        .i_wdata (bus.wdata),
        .o_rdata (w_rf_rdata),
        .o_regs  (reg_q)
    );

endmodule

`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
// ============================================================================
//  tb_apb_reg_slave
//  Directed bench driving three slaves (0, 2 and 3 wait states) from one bus.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_reg_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  sel_v = '0;
    logic        enable = 1'b0;
    logic        write  = 1'b0;
    logic [3:0]  strb   = '0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [31:0] status_in = 32'h0000_00A5;

    logic [511:0] regs0, regs2, regs3;
    logic [2:0]   rdy_v, err_v;
    logic [31:0]  rd_v [3];

    apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();
    apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

    assign if0.sel = sel_v[0]; assign if0.enable = enable; assign if0.write = write;
    assign if0.strb = strb;    assign if0.addr = addr;     assign if0.wdata = wdata;
    assign if2.sel = sel_v[1]; assign if2.enable = enable; assign if2.write = write;
    assign if2.strb = strb;    assign if2.addr = addr;     assign if2.wdata = wdata;
    assign if3.sel = sel_v[2]; assign if3.enable = enable; assign if3.write = write;
    assign if3.strb = strb;    assign if3.addr = addr;     assign if3.wdata = wdata;

    assign rdy_v = {if3.ready, if2.ready, if0.ready};
    assign err_v = {if3.slverr, if2.slverr, if0.slverr};
    assign rd_v[0] = if0.rdata;
    assign rd_v[1] = if2.rdata;
    assign rd_v[2] = if3.rdata;

    apb_reg_slave #(.NUM_REGS(16), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .status_in(status_in), .reg_q(regs0));
    apb_reg_slave #(.NUM_REGS(16), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .bus(if2.slave), .status_in(status_in), .reg_q(regs2));
    apb_reg_slave #(.NUM_REGS(16), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .bus(if3.slave), .status_in(status_in), .reg_q(regs3));

    logic [31:0] exp0 [16];

    function automatic logic [511:0] flat0();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = exp0[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ends at the negedge of the ready cycle with the bus still driven, so a
    // following call issues its setup phase in the very next cycle.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd, output logic er,
                            output int waits, output int rdy_cyc);
        @(posedge clk); #1;
        sel_v = '0; sel_v[d] = 1'b1; enable = 1'b0;
        write = wr; addr = a; wdata = wd; strb = st;
        @(posedge clk); #1;
        enable = 1'b1;
        waits = 0; rd = '0; er = 1'b0; rdy_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy_v[d]) begin
                rd = rd_v[d]; er = err_v[d]; rdy_cyc = cyc;
                break;
            end
            chk("quiet_when_not_ready", {err_v[d], rd_v[d]}, '0);
            waits++;
            @(posedge clk); #1;
        end
        chk("xfer_completed", (rdy_cyc >= 0) ? 1 : 0, 1);
    endtask

    task automatic apb_idle();
        @(posedge clk); #1;
        sel_v = '0; enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w, c1, c2;

        for (int i = 0; i < 16; i++) exp0[i] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  rdy_v, '0);
        chk("rst_slverr", err_v, '0);
        chk("rst_rdata",  {rd_v[0], rd_v[1], rd_v[2]}, '0);
        chk("rst_regs0",  regs0, '0);

        // Zero-wait write then read
        apb_xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, er, w, c1);
        chk("ws0_wr_waits", w, 0);
        chk("ws0_wr_err", er, 0);
        exp0[1] = 32'hDEADBEEF;
        apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, rd, er, w, c1);
        chk("ws0_rd_waits", w, 0);
        chk("ws0_rd_data", rd, 32'hDEADBEEF);
        chk("ws0_rd_err", er, 0);
        apb_idle();

        // Three wait states
        apb_xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, w, c1);
        chk("ws3_rd_waits", w, 3);
        chk("ws3_rd_data", rd, 32'h0);
        chk("ws3_rd_err", er, 0);
        apb_idle();

        // Partial strobes
        apb_xfer(0, 1'b1, 32'h0C, 32'h11223344, 4'hF, rd, er, w, c1);
        apb_xfer(0, 1'b1, 32'h0C, 32'hAABBCCDD, 4'b0101, rd, er, w, c1);
        chk("strb_wr_err", er, 0);
        exp0[3] = 32'h11BB33DD;
        apb_xfer(0, 1'b0, 32'h0F, 32'h0, 4'h0, rd, er, w, c1);
        chk("strb_rd_data", rd, 32'h11BB33DD);

        // Zero strobe, write to status slot, out-of-range read, status read
        apb_xfer(0, 1'b1, 32'h04, 32'h01234567, 4'h0, rd, er, w, c1);
        chk("strb0_err", er, 0);
        apb_xfer(0, 1'b1, 32'h00, 32'h12345678, 4'hF, rd, er, w, c1);
        chk("wr_idx0_err", er, 1);
        apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, w, c1);
        chk("oor_rd_err", er, 1);
        chk("oor_rd_data", rd, 32'h0);
        apb_xfer(0, 1'b1, 32'h44, 32'hFFFFFFFF, 4'hF, rd, er, w, c1);
        chk("oor_wr_err", er, 1);
        apb_xfer(0, 1'b0, 32'h00, 32'h0, 4'hF, rd, er, w, c1);
        chk("status_rd_data", rd, 32'h0000_00A5);
        chk("status_rd_err", er, 0);
        apb_idle();
        @(negedge clk);
        chk("regs0_image", regs0, flat0());

        // Abort by dropping sel during wait states
        @(posedge clk); #1;
        sel_v = 3'b010; enable = 1'b0; write = 1'b1;
        addr = 32'h10; wdata = 32'hCAFEF00D; strb = 4'hF;
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        chk("abort_ready_before", rdy_v[1], 0);
        @(posedge clk); #1 sel_v = '0; enable = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", rdy_v[1], 0);
        @(posedge clk); @(negedge clk);
        chk("abort_reg_untouched", regs2[4*32 +: 32], 32'h0);
        apb_xfer(1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, rd, er, w, c1);
        chk("after_abort_waits", w, 2);
        chk("after_abort_err", er, 0);
        apb_idle();
        @(negedge clk);
        chk("after_abort_reg", regs2[4*32 +: 32], 32'h0BADF00D);

        // Reset in the middle of a waited write
        @(posedge clk); #1;
        sel_v = 3'b010; enable = 1'b0; write = 1'b1;
        addr = 32'h14; wdata = 32'h55AA55AA; strb = 4'hF;
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", rdy_v[1], 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; sel_v = '0; enable = 1'b0;
        @(negedge clk);
        chk("rst_mid_regs2", regs2, '0);
        chk("rst_mid_ready_after", rdy_v[1], 0);

        // Back-to-back writes after reset
        apb_xfer(1, 1'b1, 32'h14, 32'hAAAA0001, 4'hF, rd, er, w, c1);
        chk("b2b_first_waits", w, 2);
        apb_xfer(1, 1'b1, 32'h18, 32'hBBBB0002, 4'hF, rd, er, w, c2);
        chk("b2b_second_waits", w, 2);
        chk("b2b_spacing", c2 - c1, 4);
        apb_idle();
        @(negedge clk);
        chk("b2b_reg5", regs2[5*32 +: 32], 32'hAAAA0001);
        chk("b2b_reg6", regs2[6*32 +: 32], 32'hBBBB0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
